// File: rtl/ifetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_pkg : shared types and constants for the instruction fetch stage     |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package ifetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam int          TIMEOUT_W = 8;

  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit : PC-driven request/grant/response fetch with held instruction  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_NOP = NOP_INSN,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        ins_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  output logic        ins_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        pc_en_o
);

  localparam logic [TIMEOUT_W-1:0] C_CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] C_CNT_MAX  = '1;

  fetch_state_e         state_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [31:0]          ins_q;
  logic [31:0]          ins_pc_q;
  logic                 valid_q;
  logic                 misalign_q;
  logic                 bus_err_q;

  logic                 w_aligned;
  logic                 w_timeout;
  logic [TIMEOUT_W-1:0] w_cnt_inc;

  assign w_aligned = is_aligned(pc_i);
  assign w_timeout = (cnt_q >= C_CNT_LAST);
  assign w_cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Request is held off while reset is asserted so the bus sees a clean idle.
  assign imem_req_o  = nrst_i && (state_q == REQ) && w_aligned;
  assign imem_addr_o = imem_req_o ? pc_i : 32'h0;
  assign pc_en_o     = (state_q == HOLD) && ins_ready_i && !flush_i;

  assign ins_o       = ins_q;
  assign ins_pc_o    = ins_pc_q;
  assign ins_valid_o = valid_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q    <= REQ;
      cnt_q      <= '0;
      ins_q      <= RESET_NOP;
      ins_pc_q   <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (flush_i) begin
            // A grant in the flush cycle still owes us a response to drain.
            if (w_aligned && imem_gnt_i) begin
              state_q <= FLUSH;
              cnt_q   <= '0;
            end
          end else if (!w_aligned) begin
            state_q    <= HOLD;
            misalign_q <= 1'b1;
            ins_q      <= RESET_NOP;
            ins_pc_q   <= pc_i;
            valid_q    <= 1'b1;
          end else if (imem_gnt_i) begin
            state_q  <= WAIT;
            ins_pc_q <= pc_i;
            cnt_q    <= '0;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state_q <= FLUSH;
            cnt_q   <= w_cnt_inc;
          end else if (imem_rvalid_i) begin
            state_q <= HOLD;
            ins_q   <= imem_rdata_i;
            valid_q <= 1'b1;
          end else if (w_timeout) begin
            state_q   <= HOLD;
            bus_err_q <= 1'b1;
            ins_q     <= RESET_NOP;
            valid_q   <= 1'b1;
          end else begin
            cnt_q <= w_cnt_inc;
          end
        end
        HOLD: begin
          if (flush_i || ins_ready_i) begin
            state_q    <= REQ;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            ins_q      <= RESET_NOP;
          end
        end
        FLUSH: begin
          if (imem_rvalid_i || w_timeout) begin
            state_q <= REQ;
          end else begin
            cnt_q <= w_cnt_inc;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly downstream of the program counter register. It takes the current PC, runs a request/grant/response handshake with instruction memory, and holds the returned instruction for the decode/execute datapath. It pulses `pc_en_o` into the PC register's enable only when the held instruction is consumed, so the PC never advances ahead of an outstanding fetch. It also detects misaligned PCs, handles fetch flushes, and enforces a memory response timeout.

## Interface
- `RESET_NOP`, default 32'h0000_0013: instruction word driven while nothing valid is held (`addi x0,x0,0`).
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before declaring a bus error; range 2..255.
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `nrst_i` in 1: reset, synchronous and active-low.
- `pc_i` in 32: current PC from the PC register.
- `flush_i` in 1: kill the current fetch (trap or redirect); `pc_i` is valid with the new target from the next cycle.
- `ins_ready_i` in 1: datapath consumes the held instruction this cycle.
- `imem_req_o` out 1: memory request.
- `imem_addr_o` out 32: request address, equal to `pc_i`.
- `imem_gnt_i` in 1: request accepted.
- `imem_rvalid_i` in 1: response data valid.
- `imem_rdata_i` in 32: response data.
- `ins_o` out 32: held instruction.
- `ins_pc_o` out 32: PC of the held instruction.
- `ins_valid_o` out 1: `ins_o` is valid.
- `misalign_o` out 1: the held entry comes from a PC with `pc[1:0]` not equal to 0.
- `bus_err_o` out 1: the held entry comes from a response timeout.
- `pc_en_o` out 1: one-cycle advance pulse to the PC register.

## Operation
- FSM states: REQ, WAIT, HOLD, FLUSH. Reset state is REQ.
- **REQ**
  - If `pc_i[1:0]` is not 0: no request is issued. Next state is HOLD with `misalign_o`=1, `ins_o`=`RESET_NOP`, `ins_pc_o`=`pc_i`.
  - Otherwise: `imem_req_o`=1 and `imem_addr_o`=`pc_i`.
  - On `imem_gnt_i`: latch `pc_i` into `ins_pc_o`, clear the timeout counter, go to WAIT.
  - Without a grant, stay in REQ and keep the request and address stable.
- **WAIT**
  - On `imem_rvalid_i`: latch `imem_rdata_i` into `ins_o`, go to HOLD.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1, go to HOLD with `bus_err_o`=1 and `ins_o`=`RESET_NOP`.
- **HOLD**
  - `ins_valid_o`=1.
  - On `ins_ready_i`: `pc_en_o`=1 for that cycle, clear the error flags, go to REQ.
- **FLUSH**
  - Entered when `flush_i` is asserted in WAIT.
  - Waits for `imem_rvalid_i` (or the timeout), discards the data, then goes to REQ.
  - `pc_en_o` stays 0 throughout.
- **`flush_i` handling**
  - In REQ with a grant not yet received: the request is withdrawn next cycle; stay in REQ.
  - In REQ in the same cycle as a grant: go to FLUSH.
  - In HOLD: drop the instruction; `pc_en_o`=0; go to REQ.
  - `flush_i` has priority over `ins_ready_i` and `imem_rvalid_i`.
- `imem_rvalid_i` is ignored in REQ and HOLD, including stray responses after reset.
- The PC is consumed combinationally; `pc_i` is stable while `pc_en_o`=0.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=0, `ins_o`=`RESET_NOP`, `ins_pc_o`=0, `ins_valid_o`=0, `misalign_o`=0, `bus_err_o`=0, `pc_en_o`=0, counter=0.
- Reset asserted mid-operation aborts any outstanding fetch. The first cycle after reset release is REQ.
- Minimum fetch latency: grant in REQ at cycle N, `rvalid` at N+1, `ins_valid_o` at N+2. A PC advance is possible at N+2, giving a new REQ at N+3.
- `imem_req_o` and `imem_addr_o` are combinational from state and `pc_i`. All other outputs are registered, except `pc_en_o`, which is the AND of (state==HOLD), `ins_ready_i` and not `flush_i`.
- Misaligned PC: HOLD is reached one cycle after REQ.
- Timeout: HOLD is reached exactly `TIMEOUT` cycles after entering WAIT.
- The counter is 8 bits and saturates; it never wraps.

## Structure
- Shared package `ifetch_pkg` holds:
  - the `fetch_state_e` enum (REQ, WAIT, HOLD, FLUSH);
  - the `NOP_INSN` constant 32'h0000_0013;
  - a `TIMEOUT_W` localparam of 8.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- **Normal fetch:** `pc_i`=0x100, grant immediate, `rvalid` next cycle with 0x00500093. Expect `ins_valid_o`=1, `ins_o`=0x00500093, `ins_pc_o`=0x100. Assert `ins_ready_i`: expect exactly one `pc_en_o` pulse.
- **Delayed grant:** `imem_gnt_i` held low for 3 cycles. Expect `imem_req_o` and `imem_addr_o`=0x104 stable throughout, then normal completion.
- **Misalign:** `pc_i`=0x102. Expect no `imem_req_o`, `misalign_o`=1, `ins_o`=0x00000013 and `ins_valid_o`=1 one cycle later.
- **Flush in WAIT:** `flush_i` asserted, then `rvalid` with 0xDEADBEEF. Expect the data discarded, `ins_valid_o` never set, and a new REQ at the new `pc_i`=0x200.
- **Timeout:** with `TIMEOUT`=16, never assert `rvalid`. Expect `bus_err_o`=1 and `ins_valid_o`=1 exactly 16 cycles after entering WAIT.
- **Reset mid-WAIT:** pull `nrst_i` low for 1 cycle while in WAIT, then send a stray `rvalid`. Expect all outputs at reset values, the stray `rvalid` ignored, and a fresh REQ.
